// File: rtl/zero_cross_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zero_cross_period_meter
//  Brief    : Rising zero-crossing detector with hysteresis; averages the
//             sample count of PERIODS periods and hands it downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module zero_cross_period_meter #(
    parameter int WIDTH       = 12,
    parameter int COUNT_WIDTH = 16,
    parameter int HYST        = 64,
    parameter int PERIODS     = 4,
    parameter int MAX_PERIOD  = 4095
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [COUNT_WIDTH-1:0] period_o,
    input  logic                   ready_i,
    output logic                   timeout_o
);

    localparam int c_log2  = $clog2(PERIODS);
    localparam int c_acc_w = COUNT_WIDTH + c_log2;
    localparam int c_idx_w = $clog2(PERIODS + 1);

    localparam logic [1:0] c_seek  = 2'd0;
    localparam logic [1:0] c_armed = 2'd1;
    localparam logic [1:0] c_high  = 2'd2;
    localparam logic [1:0] c_low   = 2'd3;

    localparam logic signed [WIDTH:0]       c_hyst_hi = (WIDTH+1)'(HYST);
    localparam logic signed [WIDTH:0]       c_hyst_lo = -c_hyst_hi;
    localparam logic [COUNT_WIDTH-1:0]      c_cnt_one = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]      c_cnt_max = COUNT_WIDTH'(MAX_PERIOD);
    localparam logic [c_idx_w-1:0]          c_idx_one = c_idx_w'(1);
    localparam logic [c_idx_w-1:0]          c_idx_end = c_idx_w'(PERIODS);

    logic [1:0]             r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [c_acc_w-1:0]     r_acc;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_period;
    logic                   r_timeout;

    logic                   w_accept;
    logic signed [WIDTH:0]  w_sample;
    logic                   w_low;
    logic                   w_high;
    logic [COUNT_WIDTH-1:0] w_count_inc;
    logic                   w_timeout_hit;
    logic [c_acc_w-1:0]     w_acc_next;
    logic [c_idx_w-1:0]     w_idx_next;
    logic                   w_done;

    // A held result blocks new samples so nothing is ever dropped.
    assign ready_o       = ~r_valid | ready_i;
    assign w_accept      = valid_i & ready_o;
    assign w_sample      = {data_i[WIDTH-1], data_i};
    assign w_low         = (w_sample <= c_hyst_lo);
    assign w_high        = (w_sample >= c_hyst_hi);
    assign w_count_inc   = r_count + c_cnt_one;
    assign w_timeout_hit = (w_count_inc == c_cnt_max);
    assign w_acc_next    = r_acc + c_acc_w'(w_count_inc);
    assign w_idx_next    = r_idx + c_idx_one;
    assign w_done        = (w_idx_next == c_idx_end);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state   <= c_seek;
            r_count   <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    c_seek: begin
                        if (w_low) begin
                            r_state <= c_armed;
                        end
                    end
                    c_armed: begin
                        if (w_high) begin
                            r_state <= c_high;
                            r_count <= '0;
                            r_acc   <= '0;
                            r_idx   <= '0;
                        end
                    end
                    c_high, c_low: begin
                        if ((r_state == c_low) && w_high) begin
                            // Measured crossing: the crossing sample closes the period.
                            r_state <= c_high;
                            r_count <= '0;
                            if (w_done) begin
                                r_period <= w_acc_next[c_log2 +: COUNT_WIDTH];
                                r_valid  <= 1'b1;
                                r_acc    <= '0;
                                r_idx    <= '0;
                            end else begin
                                r_acc <= w_acc_next;
                                r_idx <= w_idx_next;
                            end
                        end else if (w_timeout_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= c_seek;
                            r_count   <= '0;
                            r_acc     <= '0;
                            r_idx     <= '0;
                        end else begin
                            r_count <= w_count_inc;
                            if ((r_state == c_high) && w_low) begin
                                r_state <= c_low;
                            end
                        end
                    end
                    default: r_state <= c_seek;
                endcase
            end
        end
    end

    assign valid_o   = r_valid;
    assign period_o  = r_period;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_zero_cross_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_zero_cross_period_meter
//  Brief    : Directed vectors and corner sequences for zero_cross_period_meter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zero_cross_period_meter;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [11:0] data_i = '0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] period_o;
    logic        timeout_o;

    zero_cross_period_meter dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .period_o  (period_o),
        .ready_i   (ready_i),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int t_cnt = 0;
    int t_at = -1;
    int res_q[$];
    int at_q[$];

    typedef struct {
        int l0;
        int l1;
        int l2;
        int l3;
        int exp_period;
    } vec_t;

    // Each negedge with valid_o & ready_i is exactly one transfer.
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            res_q.push_back(int'(period_o));
            at_q.push_back(n_acc);
        end
        if (timeout_o) begin
            t_cnt++;
            t_at = n_acc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int q_get(input int idx, input bit which);
        if (which == 1'b0) return (idx < res_q.size()) ? res_q[idx] : -1;
        return (idx < at_q.size()) ? at_q[idx] : -1;
    endfunction

    // Triangle tone: rises from -2047 over the first half, falls back after.
    function automatic logic [11:0] tone_s(input int p, input int len);
        int half;
        int v;
        half = len / 2;
        if (p < half) v = -2047 + (4094 * p) / half;
        else          v = 2047 - (4094 * (p - half)) / (len - half);
        return 12'(v);
    endfunction

    function automatic int xpos(input int len);
        for (int p = 0; p < len; p++) begin
            if ($signed(tone_s(p, len)) >= 64) return p;
        end
        return -1;
    endfunction

    task automatic send_sample(input logic [11:0] v, input int gap);
        bit done;
        logic rdy;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = v;
            #1;
            rdy = ready_o;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                n_acc++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_stall: sample not accepted within 2000 cycles");
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_period(input int len, input int n, input int gap);
        for (int p = 0; p < n; p++) send_sample(tone_s(p, len), gap);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        valid_i  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        n_acc    = 0;
    endtask

    // Standard tone: arming period, four measured periods, closing crossing.
    task automatic tone_run(input string name, input int gap, input int exp_p);
        int base;
        base  = res_q.size();
        n_acc = 0;
        send_period(100, 100, gap);
        send_period(100, 100, gap);
        send_period(100, 100, gap);
        send_period(100, 100, gap);
        send_period(100, 100, gap);
        idle(4);
        check({name, "_count"}, res_q.size() - base, 1);
        check({name, "_period"}, q_get(base, 1'b0), exp_p);
        check({name, "_at"}, q_get(base, 1'b1), 400 + xpos(100) + 1);
    endtask

    vec_t vecs[6];

    initial begin
        int base;
        int t0;
        int acc0;
        bit stall_ok;
        bit seen;

        vecs[0] = '{100, 100, 100, 100, 100};
        vecs[1] = '{100, 101, 100, 101, 100};
        vecs[2] = '{101, 101, 101, 101, 101};
        vecs[3] = '{102, 103, 102, 103, 102};
        vecs[4] = '{50, 50, 51, 51, 50};
        vecs[5] = '{200, 201, 201, 201, 200};

        repeat (2) @(posedge clk);
        do_reset();
        check("reset_flags", {29'd0, valid_o, timeout_o, ready_o}, 1);
        check("reset_period", int'(period_o), 0);

        foreach (vecs[i]) begin
            do_reset();
            base  = res_q.size();
            send_period(vecs[i].l0, vecs[i].l0, 0);
            send_period(vecs[i].l1, vecs[i].l1, 0);
            send_period(vecs[i].l2, vecs[i].l2, 0);
            send_period(vecs[i].l3, vecs[i].l3, 0);
            send_period(vecs[i].l3, vecs[i].l3, 0);
            idle(4);
            check($sformatf("vec%0d_count", i), res_q.size() - base, 1);
            check($sformatf("vec%0d_period", i), q_get(base, 1'b0), vecs[i].exp_period);
            check($sformatf("vec%0d_at", i), q_get(base, 1'b1),
                  vecs[i].l0 + vecs[i].l1 + vecs[i].l2 + vecs[i].l3 + xpos(vecs[i].l3) + 1);
        end

        // Continuous 100-sample tone: one result every 400 accepted samples.
        do_reset();
        base = res_q.size();
        for (int k = 0; k < 9; k++) send_period(100, 100, 0);
        idle(4);
        check("cadence_count", res_q.size() - base, 2);
        check("cadence_first_at", q_get(base, 1'b1), 427);
        check("cadence_spacing", q_get(base + 1, 1'b1) - q_get(base, 1'b1), 400);
        check("cadence_second_period", q_get(base + 1, 1'b0), 100);

        do_reset();
        tone_run("toggle", 1, 100);

        // Backpressure: result held for 50 cycles, input must stall.
        do_reset();
        ready_i = 1'b0;
        base    = res_q.size();
        fork
            begin
                for (int k = 0; k < 9; k++) send_period(100, 100, 0);
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 3000 && !seen; c++) begin
                    @(posedge clk);
                    #1;
                    seen = valid_o;
                end
                check("bp_valid_seen", int'(seen), 1);
                acc0     = n_acc;
                stall_ok = 1'b1;
                repeat (50) begin
                    @(negedge clk);
                    if (ready_o !== 1'b0 || valid_o !== 1'b1 || period_o !== 16'd100)
                        stall_ok = 1'b0;
                end
                check("bp_stall_stable", int'(stall_ok), 1);
                check("bp_no_accept", n_acc - acc0, 0);
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        idle(4);
        check("bp_count", res_q.size() - base, 2);
        check("bp_period0", q_get(base, 1'b0), 100);
        check("bp_period1", q_get(base + 1, 1'b0), 100);
        check("bp_at1", q_get(base + 1, 1'b1), 827);

        // Samples inside the hysteresis band never arm or count.
        do_reset();
        base = res_q.size();
        t0   = t_cnt;
        for (int k = 0; k < 400; k++) send_sample((k % 2 == 0) ? 12'sd40 : -12'sd40, 0);
        idle(4);
        check("hyst_no_result", res_q.size() - base, 0);
        check("hyst_no_timeout", t_cnt - t0, 0);
        tone_run("hyst_tone", 0, 100);

        // Timeout: zeros after the first crossing.
        do_reset();
        t0 = t_cnt;
        send_sample(-12'sd2047, 0);
        send_sample(12'sd2047, 0);
        for (int k = 0; k < 4200; k++) send_sample(12'd0, 0);
        idle(4);
        check("timeout_count", t_cnt - t0, 1);
        check("timeout_at", t_at, 4097);
        tone_run("timeout_tone", 0, 100);

        // Reset while a result is pending and unaccepted.
        do_reset();
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) send_period(100, 100, 0);
        send_period(100, xpos(100) + 1, 0);
        idle(2);
        check("rst_pending_valid", int'(valid_o), 1);
        do_reset();
        check("rst_clear_flags", {30'd0, valid_o, ready_o}, 1);
        check("rst_clear_period", int'(period_o), 0);
        ready_i = 1'b1;
        tone_run("rst_tone", 0, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
